// File: rtl/vram_port_arbiter.sv
// Shares the free port of the framebuffer RAM between a host (m0) and a drawing engine (m1) and includes a full-memory clear sequencer.
// Ties use fixed priority (m0 wins); define VRAM_ARB_RR_EN to switch ties to round-robin.
module vram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_valid_i,
    output logic                  m0_ready_o,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_valid_i,
    output logic                  m1_ready_o,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    input  logic                  clear_start_i,
    output logic                  clear_busy_o,
    output logic                  clear_done_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_din_o,
    input  logic [DATA_WIDTH-1:0] ram_dout_i
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    clear_busy_q;
    logic                    clear_done_q, clear_done_d;
    logic                    m0_rvalid_q, m1_rvalid_q;
    logic [DATA_WIDTH-1:0]   m0_rdata_q, m1_rdata_q;
    logic                    gnt0_s, gnt1_s;
    logic                    rd0_s, rd1_s;
`ifdef VRAM_ARB_RR_EN
    logic                    last_grant_q, last_grant_d;
`endif

    // Same-cycle grant; nothing is granted during reset or while clearing.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
`ifdef VRAM_ARB_RR_EN
            // last_grant_q==1 means m1 went last, so m0 takes the tie.
            if (m0_valid_i && m1_valid_i) begin
                gnt0_s = last_grant_q;
                gnt1_s = ~last_grant_q;
            end else begin
                gnt0_s = m0_valid_i;
                gnt1_s = m1_valid_i;
            end
`else
            gnt0_s = m0_valid_i;
            gnt1_s = m1_valid_i & ~m0_valid_i;
`endif
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign rd0_s = gnt0_s & ~m0_we_i;
    assign rd1_s = gnt1_s & ~m1_we_i;

    // RAM port steering: clear sequencer, granted master, or idle.
    always_comb begin
        ram_we_o   = 1'b0;
        ram_addr_o = {ADDR_WIDTH{1'b0}};
        ram_din_o  = {DATA_WIDTH{1'b0}};
        if (rst) begin
            ram_we_o   = 1'b0;
            ram_addr_o = {ADDR_WIDTH{1'b0}};
            ram_din_o  = {DATA_WIDTH{1'b0}};
        end else if (state_q == ST_CLEAR) begin
            ram_we_o   = 1'b1;
            ram_addr_o = clr_cnt_q;
            ram_din_o  = CLEAR_VALUE;
        end else if (gnt0_s) begin
            ram_we_o   = m0_we_i;
            ram_addr_o = m0_addr_i;
            ram_din_o  = m0_wdata_i;
        end else if (gnt1_s) begin
            ram_we_o   = m1_we_i;
            ram_addr_o = m1_addr_i;
            ram_din_o  = m1_wdata_i;
        end else begin
            ram_we_o   = 1'b0;
            ram_addr_o = {ADDR_WIDTH{1'b0}};
            ram_din_o  = {DATA_WIDTH{1'b0}};
        end
    end

    // Clear sequencer next-state; a clear_start during CLEAR is dropped.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clear_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d      = ST_IDLE;
                    clear_done_d = 1'b1;
                end else begin
                    state_d      = ST_CLEAR;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

`ifdef VRAM_ARB_RR_EN
    // Remember the most recent winner for the next tie.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0_s) begin
            last_grant_d = 1'b0;
        end else if (gnt1_s) begin
            last_grant_d = 1'b1;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Round-robin history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // FSM, clear counter and clear status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= {ADDR_WIDTH{1'b0}};
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clear_busy_q <= (state_d == ST_CLEAR);
            clear_done_q <= clear_done_d;
        end
    end

    // Read responses: capture the combinational RAM output at the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= {DATA_WIDTH{1'b0}};
            m1_rdata_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            m0_rvalid_q <= rd0_s;
            m1_rvalid_q <= rd1_s;
            if (rd0_s) begin
                m0_rdata_q <= ram_dout_i;
            end
            if (rd1_s) begin
                m1_rdata_q <= ram_dout_i;
            end
        end
    end

    assign m0_ready_o   = gnt0_s;
    assign m1_ready_o   = gnt1_s;
    assign m0_rvalid_o  = m0_rvalid_q;
    assign m1_rvalid_o  = m1_rvalid_q;
    assign m0_rdata_o   = m0_rdata_q;
    assign m1_rdata_o   = m1_rdata_q;
    assign clear_busy_o = clear_busy_q;
    assign clear_done_o = clear_done_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed scenarios plus random traffic against a transaction-level model with its own RAM image.
module tb_vram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] CLR = 8'h11;

    logic          clk;
    logic          rst;
    logic          m0_valid, m0_ready, m0_we, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_valid, m1_ready, m1_we, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          clear_start, clear_busy, clear_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    logic [DW-1:0] ram [DEPTH];

    vram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE(CLR)) dut (
        .clk(clk), .rst(rst),
        .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_we_i(m0_we),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_we_i(m1_we),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .clear_start_i(clear_start), .clear_busy_o(clear_busy), .clear_done_o(clear_done),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
    );

    // Behavioural RAM on the arbitrated port: async read, sync write.
    assign ram_dout = ram[ram_addr];
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_clearing;
    int            m_clr_pos;
    int            m_last_win;
    bit            m_done;
    bit            m_rvalid [2];
    logic [DW-1:0] m_rdata  [2];

    task automatic cycle(input bit r, input bit cs,
                         input bit v0, input bit w0, input int a0, input int d0,
                         input bit v1, input bit w1, input int a1, input int d1);
        int win;
        int exp_addr;
        bit exp_we;
        bit wreq [2];
        int areq [2];
        int dreq [2];
        @(negedge clk);
        rst = r; clear_start = cs;
        m0_valid = v0; m0_we = w0; m0_addr = AW'(a0); m0_wdata = DW'(d0);
        m1_valid = v1; m1_we = w1; m1_addr = AW'(a1); m1_wdata = DW'(d1);
        wreq[0] = w0; wreq[1] = w1; areq[0] = a0; areq[1] = a1; dreq[0] = d0; dreq[1] = d1;

        win = -1;
        if (!r && !m_clearing) begin
            if (v0 && v1) begin
`ifdef VRAM_ARB_RR_EN
                win = (m_last_win == 0) ? 1 : 0;
`else
                win = 0;
`endif
            end else if (v0) win = 0;
            else if (v1) win = 1;
        end
        exp_we = 1'b0; exp_addr = 0;
        if (!r && m_clearing) begin exp_we = 1'b1; exp_addr = m_clr_pos; end
        else if (win >= 0) begin exp_we = wreq[win]; exp_addr = areq[win]; end

        #1;
        check_eq("m0_ready", 32'(m0_ready), 32'(win == 0));
        check_eq("m1_ready", 32'(m1_ready), 32'(win == 1));
        check_eq("ram_we", 32'(ram_we), 32'(exp_we));
        check_eq("ram_addr", 32'(ram_addr), 32'(exp_addr));

        @(posedge clk);
        if (r) begin
            m_clearing = 1'b0; m_clr_pos = 0; m_last_win = 1; m_done = 1'b0;
            m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0; m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (m_clearing) begin
            ref_mem[m_clr_pos] = CLR;
            m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0;
            if (m_clr_pos == DEPTH - 1) begin
                m_clearing = 1'b0; m_clr_pos = 0; m_done = 1'b1;
            end else begin
                m_clr_pos++; m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0;
            if (win >= 0) begin
                m_last_win = win;
                if (wreq[win]) ref_mem[areq[win]] = DW'(dreq[win]);
                else begin
                    m_rvalid[win] = 1'b1;
                    m_rdata[win]  = ref_mem[areq[win]];
                end
            end
            if (cs) begin m_clearing = 1'b1; m_clr_pos = 0; end
        end

        #1;
        check_eq("m0_rvalid", 32'(m0_rvalid), 32'(m_rvalid[0]));
        check_eq("m0_rdata", 32'(m0_rdata), 32'(m_rdata[0]));
        check_eq("m1_rvalid", 32'(m1_rvalid), 32'(m_rvalid[1]));
        check_eq("m1_rdata", 32'(m1_rdata), 32'(m_rdata[1]));
        check_eq("clear_busy", 32'(clear_busy), 32'(m_clearing));
        check_eq("clear_done", 32'(clear_done), 32'(m_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        rst = 1'b1; clear_start = 1'b0;
        m0_valid = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        m_clearing = 1'b0; m_clr_pos = 0; m_last_win = 1; m_done = 1'b0;
        m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0; m_rdata[0] = '0; m_rdata[1] = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = ram[i];

        // Reset state, including combinational outputs forced low with valids high
        cycle(1, 0, 1, 1, 3, 8'h55, 1, 0, 7, 0);
        cycle(1, 1, 1, 0, 3, 0, 1, 0, 7, 0);

        // Clear with m1 read held throughout, second clear_start mid-clear
        busy_cnt = 0; done_cnt = 0;
        cycle(0, 1, 0, 0, 0, 0, 1, 0, 2, 0);
        for (int i = 0; i < 19; i++) begin
            cycle(0, (i == 6), 0, 0, 0, 0, 1, 0, 15, 0);
            busy_cnt += int'(clear_busy);
            done_cnt += int'(clear_done);
        end
        check_eq("clear_busy_len", 32'(busy_cnt), 32'd15);
        check_eq("clear_done_cnt", 32'(done_cnt), 32'd1);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("read_at0", 32'(m0_rdata), 32'h11);
        cycle(0, 0, 1, 0, 15, 0, 0, 0, 0, 0);
        check_eq("read_at15", 32'(m0_rdata), 32'h11);

        // Write then read same address
        cycle(0, 0, 1, 1, 3, 8'hA5, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
        check_eq("wr_rd_a5", 32'(m0_rdata), 32'hA5);
        idle(1);

        // Sustained contention, both reading
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 3, 0, 1, 0, 4, 0);
        idle(1);

        // Clear collides with an m0 write
        cycle(0, 1, 1, 1, 5, 8'h7E, 0, 0, 0, 0);
        idle(17);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
        check_eq("collide_at5", 32'(m1_rdata), 32'h11);

        // Reset in the middle of a clear
        cycle(0, 0, 1, 1, 10, 8'h3C, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 10, 0);
        check_eq("abort_at10", 32'(m1_rdata), 32'h3C);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
        end
        idle(20);

        for (int i = 0; i < DEPTH; i++) check_eq("mem_image", 32'(ram[i]), 32'(ref_mem[i]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Owns one port of the VGA framebuffer dual-port RAM (the async-read, sync-write port left free by scanout).
- Shares that port between two requesters (m0 = host/CPU, m1 = pixel drawing engine) with a valid/ready handshake.
- Contains a built-in clear sequencer that fills the whole framebuffer with a constant.
- RAM read data is combinational; the arbiter registers it into a one-cycle read response per requester.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 10, RAM address width; depth = 2^ADDR_WIDTH
CLEAR_VALUE, 0, word written to every location by the clear sequencer

Ports:
clk  in  1  sole clock, all state on posedge
rst  in  1  synchronous active-high reset
m0_valid  in  1  requester 0 command valid
m0_ready  out  1  requester 0 command accepted this cycle
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR_WIDTH  requester 0 address
m0_wdata  in  DATA_WIDTH  requester 0 write data
m0_rvalid  out  1  requester 0 read data valid (1-cycle pulse)
m0_rdata  out  DATA_WIDTH  requester 0 read data
m1_valid, m1_ready, m1_we, m1_addr, m1_wdata, m1_rvalid, m1_rdata: same as m0, for requester 1
clear_start  in  1  start full-memory clear (pulse)
clear_busy  out  1  clear in progress
clear_done  out  1  1-cycle pulse after the final clear write
ram_we  out  1  to RAM port write enable
ram_addr  out  ADDR_WIDTH  to RAM port address
ram_din  out  DATA_WIDTH  to RAM port write data
ram_dout  in  DATA_WIDTH  from RAM port (combinational read)

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- While rst=1, every registered output and state clears: m*_rvalid=0, m*_rdata=0, clear_busy=0, clear_done=0, FSM=IDLE, clr_cnt=0, last_grant=1.
- Readies and RAM controls are combinational and are forced low while rst=1: m*_ready=0, ram_we=0, ram_addr=0, ram_din=0.
- FSM states: IDLE, CLEAR.
- IDLE:
  - Grant is combinational in the same cycle. The granted master's ready=1.
  - ram_addr, ram_we and ram_din come from the granted master's m*_addr, m*_we and m*_wdata.
  - With no grant: ram_we=0, ram_addr=0.
  - Only one ready is high in any cycle.
  - Only m0 valid: grant m0. Only m1 valid: grant m1.
  - Both valid: arbitration per the Optional Feature.
  - last_grant updates to the granted index on every grant.
- Writes: the RAM is written at the posedge of the accepted cycle.
- Reads:
  - At the posedge of the accepted read, ram_dout is captured into mX_rdata.
  - mX_rvalid=1 for exactly the next cycle, so read latency is 1 cycle.
  - mX_rdata holds its value until that requester's next read response.
- Back-to-back reads by one master are legal every cycle. rvalid stays high continuously and rdata updates each cycle.
- Write-then-read of the same address on consecutive cycles returns the new data.
- clear_start while IDLE:
  - Enter CLEAR on the next cycle.
  - A master granted in the same cycle as clear_start still completes normally.
- CLEAR:
  - Both readies=0 and masters stall (valid held).
  - ram_we=1, ram_addr=clr_cnt, ram_din=CLEAR_VALUE, clear_busy=1.
  - clr_cnt increments by 1 per cycle.
  - After the write at address 2^ADDR_WIDTH-1: clr_cnt wraps to 0, FSM goes to IDLE and clear_done=1 for that next cycle.
  - A clear takes exactly 2^ADDR_WIDTH cycles.
- clear_start while CLEAR is ignored (no restart, no queueing).
- Pending read responses (rvalid) issued in the cycle before CLEAR still emit normally.
- rst asserted mid-clear aborts the clear: IDLE, clr_cnt=0, no clear_done, and remaining locations are not written.

Optional Feature:
- Macro: VRAM_ARB_RR_EN.
- Defined: round-robin on contention. If both valid, grant the index != last_grant. last_grant=1 after reset, so m0 wins the first tie. Under sustained contention the masters alternate every cycle.
- Undefined: fixed priority, m0 always wins ties. last_grant register is removed.

Test Plan:
- Write, then read: ADDR_WIDTH=4. m0 writes 0xA5 @3; the next cycle m0 reads @3 -> m0_ready=1 both cycles; m0_rvalid=1 one cycle later with m0_rdata=0xA5; m1_rvalid stays 0.
- Contention, RR_EN defined: m0 and m1 both hold valid reads for 4 cycles -> grants m0,m1,m0,m1. Each rvalid pulses the cycle after its grant.
- Contention, RR_EN undefined: same stimulus -> m0 granted all 4 cycles, m1_ready=0.
- Clear: ADDR_WIDTH=4, CLEAR_VALUE=0x11, clear_start pulse -> clear_busy=1 for 16 cycles, addresses 0..15 written; clear_done pulses once; readbacks of @0 and @15 return 0x11. m1_valid held throughout sees ready=0 until IDLE, then is granted.
- Clear collision: clear_start in the same cycle as an m0 write 0x7E @5 -> the write is accepted, then @5 is overwritten to CLEAR_VALUE. A second clear_start mid-clear does not extend clear_busy beyond 16 cycles.
- Reset mid-clear: rst at cycle 6 of a clear -> outputs return to reset values next cycle, no clear_done. @10 retains its pre-clear value 0x3C.
